// File: rtl/data_mem_port.sv
// MEM-stage load/store unit. Steers lanes and sets byte enables for a word-wide bus.
// Checks alignment and sign/zero-extends loads. Stalls the pipeline until bus_ack or timeout.
module data_mem_port #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemDataSize,
  input  logic        MemDataSign,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AddrError,
  output logic        BusError,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [29:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic          sign_q, sign_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          berr_q, berr_d;

  logic          req;
  logic          legal;
  logic [3:0]    be_n;
  logic [31:0]   wdata_n;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_val;

  assign req = MemRead | MemWrite;

  always_comb begin
    case (MemDataSize)
      2'b11:   legal = (Address[1:0] == 2'b00);
      2'b10:   legal = ~Address[0];
      2'b01:   legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Byte enables are formed for loads too; only stores carry write data.
  always_comb begin
    case (MemDataSize)
      2'b01: begin
        be_n    = 4'b0001 << Address[1:0];
        wdata_n = {4{WriteData[7:0]}};
      end
      2'b10: begin
        be_n    = Address[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{WriteData[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = WriteData;
      end
    endcase
    if (!MemWrite) wdata_n = '0;
  end

  always_comb begin
    byte_sel = bus_rdata[{lane_q, 3'b000} +: 8];
    half_sel = bus_rdata[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b01:   load_val = {{24{sign_q & byte_sel[7]}}, byte_sel};
      2'b10:   load_val = {{16{sign_q & half_sel[15]}}, half_sel};
      default: load_val = bus_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    sign_d    = sign_q;
    lane_d    = lane_q;
    rdata_d   = rdata_q;
    berr_d    = berr_q;
    Stall     = 1'b0;
    AddrError = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req) begin
          if (legal) begin
            Stall   = 1'b1;
            addr_d  = Address[31:2];
            we_d    = MemWrite;
            be_d    = be_n;
            wdata_d = wdata_n;
            size_d  = MemDataSize;
            sign_d  = MemDataSign;
            lane_d  = Address[1:0];
            state_d = BUSY;
          end else begin
            AddrError = 1'b1;
          end
        end
      end

      BUSY: begin
        Stall = 1'b1;
        cnt_d = cnt_q + CW'(1);
        // An ack on the final allowed cycle still completes the access normally.
        if (bus_ack) begin
          rdata_d = we_q ? '0 : load_val;
          berr_d  = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          berr_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        cnt_d   = '0;
        berr_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        berr_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      lane_q  <= '0;
      rdata_q <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      lane_q  <= lane_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
    end
  end

  assign bus_req   = (state_q == BUSY);
  assign bus_we    = we_q;
  assign bus_be    = be_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign ReadData  = rdata_q;
  assign BusError  = berr_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Self-checking bench for data_mem_port: directed cases, then random accesses.
// Expected values come from an arithmetic reference model.
module tb_data_mem_port;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, MemDataSign;
  logic [1:0]  MemDataSize;
  logic [31:0] Address, WriteData;
  logic [31:0] ReadData;
  logic        Stall, AddrError, BusError;
  logic        bus_req, bus_we, bus_ack;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  data_mem_port #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemDataSize(MemDataSize), .MemDataSign(MemDataSign),
    .Address(Address), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall),
    .AddrError(AddrError), .BusError(BusError),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Access of n bytes at lane a%4; replication factor (2^32-1)/(2^(8n)-1) copies the datum into every lane.
  function automatic void model(input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                output logic legal, output logic [3:0] be,
                                output logic [31:0] wdx, output logic [31:0] rv);
    logic [63:0] n, lane, span, v, a64;
    a64   = 64'(a);
    n     = (sz == 2'd3) ? 64'd4 : (sz == 2'd2) ? 64'd2 : 64'd1;
    lane  = a64 % 64'd4;
    legal = (sz != 2'd0) && (a64 % n == 64'd0);
    span  = 64'd1 << (64'd8 * n);
    be    = 4'(((64'd1 << n) - 64'd1) << lane);
    wdx   = 32'((64'(wd) % span) * (64'hFFFF_FFFF / (span - 64'd1)));
    v     = (64'(rd) >> (64'd8 * lane)) % span;
    if (sg && n < 64'd4 && v >= span / 64'd2) v = v + 64'h1_0000_0000 - span;
    rv    = 32'(v);
  endfunction

  // ackd: BUSY cycle (1-based) on which bus_ack is driven; 0 or >TO means never.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                        input int unsigned ackd);
    logic        legal, tmo;
    logic [3:0]  be;
    logic [31:0] wdx, rv;
    int unsigned busy, exp_busy;
    model(sz, sg, a, wd, rdat, legal, be, wdx, rv);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; MemDataSize = sz; MemDataSign = sg;
    Address = a; WriteData = wd; bus_ack = 1'b0;
    #1;
    if (!legal) begin
      chk1("addrerr_pulse", AddrError, 1'b1);
      chk1("addrerr_stall", Stall, 1'b0);
      chk1("addrerr_req", bus_req, 1'b0);
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0;
      #1;
      chk1("addrerr_clear", AddrError, 1'b0);
      chk1("addrerr_idle_req", bus_req, 1'b0);
      return;
    end
    chk1("req_stall", Stall, 1'b1);
    chk1("req_addrerr", AddrError, 1'b0);
    chk1("req_bus_idle", bus_req, 1'b0);
    tmo      = (ackd == 0 || ackd > TO);
    exp_busy = tmo ? TO : ackd;
    busy     = 0;
    while (busy < TO + 4) begin
      @(negedge clk);
      if (Stall !== 1'b1) break;
      busy++;
      chk1("busy_req", bus_req, 1'b1);
      chk1("busy_we", bus_we, wr);
      chk("busy_addr", {2'b00, bus_addr}, {2'b00, a[31:2]});
      chk("busy_be", {28'd0, bus_be}, {28'd0, be});
      chk("busy_wdata", bus_wdata, wr ? wdx : 32'd0);
      if (busy == ackd) begin
        bus_ack = 1'b1; bus_rdata = rdat;
      end else begin
        bus_ack = 1'b0; bus_rdata = $urandom;
      end
    end
    chk("busy_cycles", busy, exp_busy);
    bus_ack = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    chk1("done_req", bus_req, 1'b0);
    chk("done_rdata", ReadData, (wr || tmo) ? 32'd0 : rv);
    chk1("done_buserr", BusError, tmo);
    chk1("done_addrerr", AddrError, 1'b0);
    // Request is still held through DONE; it must not start a new access.
    @(negedge clk);
    bus_ack = 1'b0;
    chk1("after_done_req", bus_req, 1'b0);
    chk1("after_done_buserr", BusError, 1'b0);
    MemRead = 1'b0; MemWrite = 1'b0;
    #1;
    chk1("after_done_stall", Stall, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; MemDataSize = 2'b00; MemDataSign = 1'b0;
    Address = '0; WriteData = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    chk1("rst_req", bus_req, 1'b0);
    chk1("rst_we", bus_we, 1'b0);
    chk("rst_be", {28'd0, bus_be}, 32'd0);
    chk("rst_addr", {2'b00, bus_addr}, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", ReadData, 32'd0);
    chk1("rst_addrerr", AddrError, 1'b0);
    chk1("rst_buserr", BusError, 1'b0);
    chk1("rst_stall", Stall, 1'b0);
    reset = 1'b0;

    // Ack while IDLE with no request is ignored.
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    chk1("idle_ack_req", bus_req, 1'b0);
    chk("idle_ack_rdata", ReadData, 32'd0);

    access(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_1003, 32'h0,         32'h80FF_1234, 1);  // LB
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_2002, 32'h0,         32'h8001_ABCD, 3);  // LHU
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h1234_56AB, 32'h5555_5555, 2);  // SB
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0002, 32'hDEAD_BEEF, 32'h5555_5555, 1);  // SH
    access(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0006, 32'h0,         32'h0,         1);  // LW misaligned
    access(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0001, 32'h0,         32'h0,         1);  // LH misaligned
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         1);  // invalid size
    access(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 0);  // LW timeout
    access(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0014, 32'h0,         32'h1357_9BDF, TO); // ack on last cycle
    access(1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_0020, 32'hA5A5_0F0F, 32'h1111_1111, 2);  // both: write
    access(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0102, 32'h0,         32'h9234_5678, 1);  // LH upper, sign
    access(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0,         32'h00F0_0000, 4);  // LBU lane 2

    // Reset on BUSY cycle 5: next cycle IDLE, late ack ignored.
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; MemDataSize = 2'b11; Address = 32'h0000_0040;
    #1;
    chk1("rstbusy_req_stall", Stall, 1'b1);
    for (int unsigned i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk1("rstbusy_busy_req", bus_req, 1'b1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; MemRead = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    #1;
    chk1("rstbusy_idle_req", bus_req, 1'b0);
    chk1("rstbusy_idle_stall", Stall, 1'b0);
    chk1("rstbusy_buserr", BusError, 1'b0);
    @(negedge clk);
    bus_ack = 1'b0;
    chk1("rstbusy_late_ack_req", bus_req, 1'b0);
    chk1("rstbusy_late_ack_buserr", BusError, 1'b0);
    chk("rstbusy_late_ack_rdata", ReadData, 32'd0);

    for (int unsigned i = 0; i < 40; i++) begin
      logic        r, w;
      int unsigned ad;
      r  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1'b1;
      ad = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
      access(r, w, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, ad);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
